// File: rtl/ahb_slave_regbank_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_regbank_if
// Purpose : bundles the AHB-Lite bus signals that pass between a master (or
//           testbench) and the ahb_slave_regbank responder.
// Signals :
//   Haddr     [31:0] transfer address              (master -> slave)
//   Htrans    [1:0]  IDLE/BUSY/NONSEQ/SEQ          (master -> slave)
//   Hwrite           1 = write, 0 = read           (master -> slave)
//   Hsize     [2:0]  byte/half/word                (master -> slave)
//   Hreadyin         bus HREADY                    (master -> slave)
//   Hwdata    [31:0] write data, data phase        (master -> slave)
//   Hreadyout        0 stretches the data phase    (slave -> master)
//   Hresp     [1:0]  00 OKAY, 01 ERROR             (slave -> master)
//   Hrdata    [31:0] read data                     (slave -> master)
// Clock and reset are plain ports on the responder, not part of this bundle.
// ---------------------------------------------------------------------------
interface ahb_slave_regbank_if;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic        Hreadyin;
  logic [31:0] Hwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  modport master (
    output Haddr, Htrans, Hwrite, Hsize, Hreadyin, Hwdata,
    input  Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Haddr, Htrans, Hwrite, Hsize, Hreadyin, Hwdata,
    output Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_slave_regbank.sv
// ---------------------------------------------------------------------------
// ahb_slave_regbank
// Purpose : AHB-Lite responder that terminates transfers with a local bank of
//           DEPTH 32-bit registers. The address phase is captured, then the
//           data phase is stretched by WAIT_STATES cycles and completed with
//           OKAY, or with a two-cycle ERROR for illegal transfers.
// Ports   :
//   i_Hclk    in  bus clock, all state on the rising edge
//   i_Hreset  in  asynchronous active-high reset
//   io_bus    ahb_slave_regbank_if.slave (Haddr/Htrans/Hwrite/Hsize/Hreadyin/
//             Hwdata in, Hreadyout/Hresp/Hrdata out)
// ---------------------------------------------------------------------------
module ahb_slave_regbank #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  i_Hclk,
  input  logic                  i_Hreset,
  ahb_slave_regbank_if.slave    io_bus
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DPHASE,
    ERR1,
    ERR2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_count;
  logic [IDX_W-1:0] r_idx;
  logic             r_write;
  logic [1:0]       r_size;
  logic [1:0]       r_lane;
  logic             r_readyout;
  logic [1:0]       r_resp;
  logic [31:0]      r_regs [DEPTH];

  logic             w_sel;
  logic             w_acc;
  logic             w_offsetOk;
  logic             w_sizeOk;
  logic             w_alignOk;
  logic             w_legal;
  logic [3:0]       w_byteEn;

  // Address-phase decode. A transfer is only taken when the bus is ready,
  // this responder is not stretching a data phase, the region matches and
  // the master is issuing NONSEQ/SEQ.
  assign w_sel      = (io_bus.Haddr[31:28] == BASE_ADDR[31:28]);
  assign w_acc      = io_bus.Hreadyin & r_readyout & w_sel & io_bus.Htrans[1];
  assign w_offsetOk = (io_bus.Haddr[27:0] < 28'(DEPTH * 4));
  assign w_sizeOk   = (io_bus.Hsize <= 3'b010);
  assign w_alignOk  = (io_bus.Hsize == 3'b000) ||
                      ((io_bus.Hsize == 3'b001) && (io_bus.Haddr[0] == 1'b0)) ||
                      ((io_bus.Hsize == 3'b010) && (io_bus.Haddr[1:0] == 2'b00));
  assign w_legal    = w_offsetOk & w_sizeOk & w_alignOk;

  // Byte lanes touched by the captured transfer. Half-words use the lane pair
  // picked by address bit 1; illegal sizes never reach DPHASE so the word
  // case doubles as default.
  always_comb begin
    w_byteEn = 4'b0000;
    case (r_size)
      2'b00:   w_byteEn = 4'b0001 << r_lane;
      2'b01:   w_byteEn = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_byteEn = 4'b1111;
    endcase
  end

  // Transfer FSM. Hreadyout/Hresp are registered alongside the state so they
  // change only on clock edges. Every Hreadyout=1 state can accept a new
  // address phase, which lets pipelined transfers run without a bubble.
  always_ff @(posedge i_Hclk or posedge i_Hreset) begin
    if (i_Hreset) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_lane     <= 2'b00;
      r_readyout <= 1'b1;
      r_resp     <= RESP_OKAY;
    end else begin
      case (r_state)
        IDLE, DPHASE, ERR2: begin
          if (w_acc && w_legal) begin
            r_idx   <= io_bus.Haddr[IDX_W+1:2];
            r_write <= io_bus.Hwrite;
            r_size  <= io_bus.Hsize[1:0];
            r_lane  <= io_bus.Haddr[1:0];
            r_resp  <= RESP_OKAY;
            if (WAIT_STATES == 0) begin
              r_state    <= DPHASE;
              r_readyout <= 1'b1;
            end else begin
              r_state    <= WAIT;
              r_count    <= WAIT_INIT;
              r_readyout <= 1'b0;
            end
          end else if (w_acc) begin
            r_state    <= ERR1;
            r_readyout <= 1'b0;
            r_resp     <= RESP_ERR;
          end else begin
            r_state    <= IDLE;
            r_readyout <= 1'b1;
            r_resp     <= RESP_OKAY;
          end
        end
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state    <= DPHASE;
            r_readyout <= 1'b1;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        ERR1: begin
          r_state    <= ERR2;
          r_readyout <= 1'b1;
          r_resp     <= RESP_ERR;
        end
        default: begin
          r_state    <= IDLE;
          r_readyout <= 1'b1;
          r_resp     <= RESP_OKAY;
        end
      endcase
    end
  end

  // Register bank. A write lands on the edge that ends DPHASE, so a read
  // pipelined right behind it sees the new value in its own data phase.
  // Reset during the data phase wins, so an aborted write never commits.
  always_ff @(posedge i_Hclk or posedge i_Hreset) begin
    if (i_Hreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if ((r_state == DPHASE) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byteEn[b]) begin
          r_regs[r_idx][8*b +: 8] <= io_bus.Hwdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is driven only in the final data cycle; everywhere else,
  // including both ERROR cycles, the bus sees zero.
  assign io_bus.Hreadyout = r_readyout;
  assign io_bus.Hresp     = r_resp;
  assign io_bus.Hrdata    = (r_state == DPHASE) ? r_regs[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_regbank.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_regbank
// Drives two responders (zero and two wait states) with directed AHB-Lite
// transfers. Expected responses are queued when a transfer is issued and a
// negedge monitor pops them as each data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_slave_regbank;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ahb_slave_regbank_if bus0 ();
  ahb_slave_regbank_if bus1 ();

  ahb_slave_regbank #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .i_Hclk   (clk),
    .i_Hreset (rst),
    .io_bus   (bus0.slave)
  );

  ahb_slave_regbank #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(2)) dut1 (
    .i_Hclk   (clk),
    .i_Hreset (rst),
    .io_bus   (bus1.slave)
  );

  typedef struct {
    string       name;
    logic [1:0]  resp;
    int          waits;
    bit          chkData;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          vectorsApplied = 0;
  int          miscompares    = 0;
  logic [31:0] nextWdata [2];
  bit          pending [2];
  int          waitCnt [2];

  // Single comparison point so every check is counted the same way.
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic getRdy(input int d);
    return (d == 0) ? bus0.Hreadyout : bus1.Hreadyout;
  endfunction

  function automatic logic [1:0] getResp(input int d);
    return (d == 0) ? bus0.Hresp : bus1.Hresp;
  endfunction

  task automatic driveBus(input int d, input logic [1:0] trans, input logic [31:0] addr,
                          input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    if (d == 0) begin
      bus0.Htrans = trans; bus0.Haddr = addr; bus0.Hwrite = wr;
      bus0.Hsize = size; bus0.Hwdata = wdata; bus0.Hreadyin = 1'b1;
    end else begin
      bus1.Htrans = trans; bus1.Haddr = addr; bus1.Hwrite = wr;
      bus1.Hsize = size; bus1.Hwdata = wdata; bus1.Hreadyin = 1'b1;
    end
  endtask

  // Presents one address phase (with the previous transfer's write data on
  // Hwdata), queues the expected response and returns just after the edge
  // that accepts it.
  task automatic applyStimulus(input int d, input string name, input logic [1:0] trans,
                               input logic [31:0] addr, input logic wr, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [1:0] expResp,
                               input int expWaits, input bit chkData, input logic [31:0] expRdata);
    exp_t e;
    int   budget;
    if (trans[1] && (addr[31:28] == 4'h8)) begin
      e.name = name; e.resp = expResp; e.waits = expWaits;
      e.chkData = chkData; e.rdata = expRdata;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    driveBus(d, trans, addr, wr, size, nextWdata[d]);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!getRdy(d) && budget < 40);
    if (!getRdy(d)) begin
      vectorsApplied++;
      miscompares++;
      $display("[TB] FAIL %s timeout: Hreadyout still 0 after %0d cycles, wanted 1", name, budget);
    end
    @(posedge clk);
    #1;
    nextWdata[d] = wdata;
  endtask

  task automatic doWrite(input int d, input string name, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input int waits);
    applyStimulus(d, name, 2'b10, addr, 1'b1, size, wdata, 2'b00, waits, 1'b0, 32'h0);
  endtask

  task automatic doRead(input int d, input string name, input logic [31:0] addr,
                        input logic [31:0] expData, input int waits);
    applyStimulus(d, name, 2'b10, addr, 1'b0, 3'b010, 32'h0, 2'b00, waits, 1'b1, expData);
  endtask

  task automatic doError(input int d, input string name, input logic [31:0] addr,
                         input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    applyStimulus(d, name, 2'b10, addr, wr, size, wdata, 2'b01, 1, 1'b1, 32'h0);
  endtask

  task automatic doIdle(input int d);
    applyStimulus(d, "idle", 2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 2'b00, 0, 1'b0, 32'h0);
  endtask

  // Non-transfers must leave the responder ready with OKAY.
  task automatic checkIdle(input int d, input string name);
    @(negedge clk);
    compare({name, " rdy"}, 32'(getRdy(d)), 32'h1);
    compare({name, " resp"}, 32'(getResp(d)), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Monitor step: counts stretched cycles of a pending data phase and, when
  // Hreadyout rises, pops the oldest expectation and compares against it.
  task automatic checkOutput(input int d, input logic rdy, input logic [1:0] resp,
                             input logic [31:0] rdata, input logic [1:0] trans,
                             input logic [31:0] addr, input logic readyin);
    exp_t e;
    if (rst) begin
      pending[d] = 1'b0;
      waitCnt[d] = 0;
      return;
    end
    if (pending[d]) begin
      if (!rdy) begin
        waitCnt[d]++;
      end else if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL dut%0d completion: got an unexpected response, wanted none", d);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        compare({e.name, " resp"}, 32'(resp), 32'(e.resp));
        compare({e.name, " waits"}, 32'(waitCnt[d]), 32'(e.waits));
        if (e.chkData) compare({e.name, " rdata"}, rdata, e.rdata);
      end
    end
    if (rdy) begin
      pending[d] = trans[1] && readyin && (addr[31:28] == 4'h8);
      waitCnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, bus0.Hreadyout, bus0.Hresp, bus0.Hrdata, bus0.Htrans, bus0.Haddr, bus0.Hreadyin);
    checkOutput(1, bus1.Hreadyout, bus1.Hresp, bus1.Hrdata, bus1.Htrans, bus1.Haddr, bus1.Hreadyin);
  end

  // Hard stop in case something wedges the stimulus process.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, wanted it finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nextWdata[0] = 32'h0;
    nextWdata[1] = 32'h0;
    driveBus(0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0);
    driveBus(1, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0);

    // Reset values on both responders
    repeat (2) @(negedge clk);
    compare("rst0 rdy", 32'(bus0.Hreadyout), 32'h1);
    compare("rst0 resp", 32'(bus0.Hresp), 32'h0);
    compare("rst0 rdata", bus0.Hrdata, 32'h0);
    compare("rst1 rdy", 32'(bus1.Hreadyout), 32'h1);
    compare("rst1 resp", 32'(bus1.Hresp), 32'h0);
    compare("rst1 rdata", bus1.Hrdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-stream: write, read back, then abort a second write with reset
    doWrite(0, "t1 wr", 32'h8000_0004, 3'b010, 32'h5555_AAAA, 0);
    doRead (0, "t1 rd", 32'h8000_0004, 32'h5555_AAAA, 0);
    doIdle (0);
    driveBus(0, 2'b10, 32'h8000_0004, 1'b1, 3'b010, 32'h0);
    @(posedge clk);
    #1;
    driveBus(0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    compare("t1 abort rdy", 32'(bus0.Hreadyout), 32'h1);
    compare("t1 abort resp", 32'(bus0.Hresp), 32'h0);
    compare("t1 abort rdata", bus0.Hrdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nextWdata[0] = 32'h0;
    doRead(0, "t1 rd after rst", 32'h8000_0004, 32'h0, 0);

    // Byte and half-word lanes
    doWrite(0, "t2 byte wr", 32'h8000_0001, 3'b000, 32'h0000_A300, 0);
    doRead (0, "t2 rd", 32'h8000_0000, 32'h0000_A300, 0);
    doWrite(0, "t2 half wr", 32'h8000_0012, 3'b001, 32'hBEEF_0000, 0);
    doWrite(0, "t2 byte3 wr", 32'h8000_0013, 3'b000, 32'h7700_0000, 0);
    doRead (0, "t2 rd reg4", 32'h8000_0010, 32'h77EF_0000, 0);
    doRead (0, "t2 rd unwritten", 32'h8000_0020, 32'h0, 0);

    // Range and alignment errors, then confirm nothing was written
    doError(0, "t4 out of range", 32'h8000_0100, 1'b0, 3'b010, 32'h0);
    doError(0, "t4 word misalign", 32'h8000_0002, 1'b1, 3'b010, 32'hFFFF_FFFF);
    doError(0, "t4 half misalign", 32'h8000_0001, 1'b1, 3'b001, 32'hFFFF_FFFF);
    doError(0, "t4 bad size", 32'h8000_0000, 1'b1, 3'b011, 32'hFFFF_FFFF);
    doRead (0, "t4 rd unchanged", 32'h8000_0000, 32'h0000_A300, 0);
    doWrite(0, "t4 last reg wr", 32'h8000_003C, 3'b010, 32'h0BAD_F00D, 0);
    doError(0, "t4 just past end", 32'h8000_0040, 1'b1, 3'b010, 32'hFFFF_FFFF);
    doRead (0, "t4 last reg rd", 32'h8000_003C, 32'h0BAD_F00D, 0);

    // Back-to-back write then read of the same register
    doWrite(0, "t5 wr", 32'h8000_000C, 3'b010, 32'hDEAD_BEEF, 0);
    doRead (0, "t5 rd", 32'h8000_000C, 32'hDEAD_BEEF, 0);

    // BUSY, IDLE and unselected region are ignored
    applyStimulus(0, "t6 busy", 2'b01, 32'h8000_0000, 1'b1, 3'b010, 32'hFFFF_FFFF,
                  2'b00, 0, 1'b0, 32'h0);
    checkIdle(0, "t6 busy");
    applyStimulus(0, "t6 idle", 2'b00, 32'h8000_0000, 1'b1, 3'b010, 32'hFFFF_FFFF,
                  2'b00, 0, 1'b0, 32'h0);
    checkIdle(0, "t6 idle");
    applyStimulus(0, "t6 unsel", 2'b10, 32'h4000_0000, 1'b1, 3'b010, 32'hFFFF_FFFF,
                  2'b00, 0, 1'b0, 32'h0);
    checkIdle(0, "t6 unsel");
    doRead(0, "t6 rd unchanged", 32'h8000_0000, 32'h0000_A300, 0);
    doIdle(0);
    doIdle(0);

    // Two wait states
    doWrite(1, "t3 wr", 32'h8000_0008, 3'b010, 32'hCAFE_1234, 2);
    doRead (1, "t3 rd", 32'h8000_0008, 32'hCAFE_1234, 2);
    doError(1, "t3 err", 32'h8000_0100, 1'b0, 3'b010, 32'h0);
    doRead (1, "t3 rd2", 32'h8000_0008, 32'hCAFE_1234, 2);
    doIdle(1);
    doIdle(1);

    repeat (3) @(negedge clk);
    compare("q0 drained", 32'(q0.size()), 32'h0);
    compare("q1 drained", 32'(q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
